// File: rtl/match_controller.sv
// Pingpong match sequencer: serve/rally/point/game-over flow, ball step strobe
// generation with optional speed-up, score keeping and winner declaration.
module match_controller #(
  parameter int BALL_SIZE    = 30,
  parameter int FIELD_W      = 1024,
  parameter int TICK_DIV     = 100000,
  parameter int MIN_DIV      = 20000,
  parameter int SPEEDUP      = 4,
  parameter int SERVE_TICKS  = 200,
  parameter int FREEZE_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  rule,
  input  logic [10:0] ball_posx,
  output logic        b_rst,
  output logic        b_clk,
  output logic [3:0]  p1_point,
  output logic [3:0]  p2_point,
  output logic        serve_dir,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [31:0] DIV_INIT    = 32'(TICK_DIV);
  localparam logic [31:0] DIV_FLOOR   = 32'(MIN_DIV);
  localparam logic [31:0] DIV_STEP    = 32'(SPEEDUP);
  localparam logic [31:0] DIV_STEP_OK = DIV_FLOOR + DIV_STEP;
  localparam logic [15:0] SERVE_LAST  = 16'(SERVE_TICKS - 1);
  localparam logic [15:0] FREEZE_LAST = 16'(FREEZE_TICKS - 1);
  localparam logic [11:0] RIGHT_EDGE  = 12'(FIELD_W);
  localparam logic [11:0] BALL_W      = 12'(BALL_SIZE);

  state_t      cur_state, nxt_state;
  logic        start_d, start_rise;
  logic [31:0] cnt, div;
  logic        tick;
  logic [15:0] tcnt;
  logic        long_match;
  logic        p1_hit, p2_hit, scored;
  logic [4:0]  score_sum;
  logic        limit_hit;
  logic        state_change;
  logic        unused_rule;

  assign unused_rule  = rule[0];
  assign start_rise   = start & ~start_d;
  assign tick         = (cnt == div);
  // Left wall has priority if both hit conditions are ever forced together.
  assign p2_hit       = (cur_state == RALLY) && (ball_posx == 11'd0);
  assign p1_hit       = (cur_state == RALLY) && !p2_hit &&
                        (({1'b0, ball_posx} + BALL_W) == RIGHT_EDGE);
  assign scored       = p1_hit | p2_hit;
  assign score_sum    = {1'b0, p1_point} + {1'b0, p2_point};
  assign limit_hit    = score_sum >= (long_match ? 5'd5 : 5'd3);
  assign state_change = (nxt_state != cur_state);

  assign b_rst     = (cur_state == RALLY);
  assign game_over = (cur_state == OVER);
  assign state     = cur_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= IDLE;
    else      cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (start_rise) nxt_state = SERVE;
      SERVE:   if (tick && tcnt == SERVE_LAST) nxt_state = RALLY;
      RALLY:   if (scored) nxt_state = POINT;
      POINT:   if (tick && tcnt == FREEZE_LAST) nxt_state = limit_hit ? OVER : SERVE;
      OVER:    if (start_rise) nxt_state = SERVE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_d <= 1'b0;
    else      start_d <= start;
  end

  // Free-running tick divider; the ball speeds up only while a rally is live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 32'd0;
      div   <= DIV_INIT;
      b_clk <= 1'b0;
    end else begin
      cnt   <= tick ? 32'd0 : cnt + 32'd1;
      b_clk <= (cur_state == RALLY) && tick && !scored;
      if (state_change && nxt_state == SERVE)
        div <= DIV_INIT;
      else if (cur_state == RALLY && tick && !scored && rule[1])
        div <= (div >= DIV_STEP_OK) ? div - DIV_STEP : DIV_FLOOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  tcnt <= 16'd0;
    else if (state_change)     tcnt <= 16'd0;
    else if (tick && (cur_state == SERVE || cur_state == POINT))
                               tcnt <= tcnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_point   <= 4'd0;
      p2_point   <= 4'd0;
      serve_dir  <= 1'b0;
      winner     <= 2'b00;
      long_match <= 1'b0;
    end else begin
      if (cur_state == IDLE) begin
        p1_point <= 4'd0;
        p2_point <= 4'd0;
      end
      if ((cur_state == IDLE || cur_state == OVER) && start_rise) begin
        long_match <= rule[2];
        p1_point   <= 4'd0;
        p2_point   <= 4'd0;
        winner     <= 2'b00;
      end
      if (p2_hit) begin
        p2_point  <= (p2_point == 4'hF) ? p2_point : p2_point + 4'd1;
        serve_dir <= 1'b0;
      end else if (p1_hit) begin
        p1_point  <= (p1_point == 4'hF) ? p1_point : p1_point + 4'd1;
        serve_dir <= 1'b1;
      end
      if (state_change && nxt_state == OVER) begin
        if (p1_point > p2_point)      winner <= 2'b01;
        else if (p2_point > p1_point) winner <= 2'b10;
        else                          winner <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller using a shortened tick
// divider so a full match runs in a few hundred cycles.
module tb_match_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  rule;
  logic [10:0] ball_posx;
  logic        b_rst, b_clk, serve_dir, game_over;
  logic [3:0]  p1_point, p2_point;
  logic [1:0]  winner;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  match_controller #(
    .BALL_SIZE(30), .FIELD_W(1024), .TICK_DIV(4), .MIN_DIV(2),
    .SPEEDUP(1), .SERVE_TICKS(2), .FREEZE_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rule(rule), .ball_posx(ball_posx),
    .b_rst(b_rst), .b_clk(b_clk), .p1_point(p1_point), .p2_point(p2_point),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk); n++;
      if (state === target) ok = 1'b1;
    end
  endtask

  task automatic wait_leave(input logic [2:0] from, input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk); n++;
      if (state !== from) ok = 1'b1;
    end
  endtask

  task automatic wait_bclk(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (!ok && cycles < budget) begin
      @(negedge clk); cycles++;
      if (b_clk === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_ball(input logic [10:0] x);
    ball_posx = x;
    @(negedge clk);
    ball_posx = 11'd500;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; rule = 3'b000; ball_posx = 11'd500;
    repeat (3) @(negedge clk);
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    vectors++; if (b_rst !== 1'b0 || b_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ball: b_rst=%b b_clk=%b want 0 0", b_rst, b_clk); end
    vectors++; if (p1_point !== 4'd0 || p2_point !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_score: got %0d/%0d want 0/0", p1_point, p2_point); end
    vectors++; if (winner !== 2'b00 || game_over !== 1'b0 || serve_dir !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags: winner=%b over=%b dir=%b want 00 0 0", winner, game_over, serve_dir); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL idle_hold: got %0d want 0", state); end
  endtask

  task automatic test_start_serve();
    bit ok; int c;
    pulse_start();
    vectors++; if (state !== 3'd1) begin miscompares++; $display("[TB] FAIL start_serve: got %0d want 1", state); end
    vectors++; if (b_rst !== 1'b0) begin miscompares++; $display("[TB] FAIL serve_hold: b_rst=%b want 0", b_rst); end
    wait_state(3'd2, 40, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL serve_to_rally: timeout, state=%0d want 2", state); end
    vectors++; if (b_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL rally_release: b_rst=%b want 1", b_rst); end
    wait_bclk(20, c, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL first_bclk: timeout after %0d cycles", c); end
    for (int i = 0; i < 2; i++) begin
      wait_bclk(20, c, ok);
      vectors++; if (c !== 5) begin miscompares++; $display("[TB] FAIL bclk_period[%0d]: got %0d want 5", i, c); end
    end
  endtask

  task automatic test_point_p1();
    bit ok;
    pulse_start();
    vectors++; if (state !== 3'd2) begin miscompares++; $display("[TB] FAIL start_ignored_rally: got %0d want 2", state); end
    drive_ball(11'd994);
    vectors++; if (p1_point !== 4'd1 || p2_point !== 4'd0) begin miscompares++; $display("[TB] FAIL p1_score: got %0d/%0d want 1/0", p1_point, p2_point); end
    vectors++; if (state !== 3'd3 || b_rst !== 1'b0) begin miscompares++; $display("[TB] FAIL p1_point_state: state=%0d b_rst=%b want 3 0", state, b_rst); end
    vectors++; if (serve_dir !== 1'b1 || b_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL p1_dir: dir=%b b_clk=%b want 1 0", serve_dir, b_clk); end
    wait_leave(3'd3, 40, ok);
    vectors++; if (!ok || state !== 3'd1) begin miscompares++; $display("[TB] FAIL freeze_to_serve: state=%0d want 1", state); end
  endtask

  task automatic test_speedup();
    bit ok; int c;
    int exp_sp[5] = '{5, 4, 3, 3, 3};
    wait_state(3'd2, 40, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL speed_rally: timeout, state=%0d want 2", state); end
    wait_bclk(20, c, ok);
    rule = 3'b010;
    for (int i = 0; i < 5; i++) begin
      wait_bclk(20, c, ok);
      vectors++; if (c !== exp_sp[i]) begin miscompares++; $display("[TB] FAIL speed_gap[%0d]: got %0d want %0d", i, c, exp_sp[i]); end
    end
    rule = 3'b000;
    drive_ball(11'd0);
    vectors++; if (p2_point !== 4'd1 || p1_point !== 4'd1) begin miscompares++; $display("[TB] FAIL p2_score: got %0d/%0d want 1/1", p1_point, p2_point); end
    vectors++; if (serve_dir !== 1'b0 || state !== 3'd3) begin miscompares++; $display("[TB] FAIL p2_dir: dir=%b state=%0d want 0 3", serve_dir, state); end
    wait_leave(3'd3, 40, ok);
    vectors++; if (!ok || state !== 3'd1) begin miscompares++; $display("[TB] FAIL sum2_serve: state=%0d want 1", state); end
  endtask

  task automatic test_tick_collision();
    bit ok; int c;
    wait_state(3'd2, 40, ok);
    wait_bclk(20, c, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL collide_sync: no b_clk within %0d cycles", c); end
    repeat (4) @(negedge clk);
    drive_ball(11'd0);
    vectors++; if (b_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL collide_bclk: got %b want 0", b_clk); end
    vectors++; if (p2_point !== 4'd2 || state !== 3'd3) begin miscompares++; $display("[TB] FAIL collide_score: p2=%0d state=%0d want 2 3", p2_point, state); end
  endtask

  task automatic test_game_over();
    bit ok;
    wait_leave(3'd3, 40, ok);
    vectors++; if (state !== 3'd4 || game_over !== 1'b1) begin miscompares++; $display("[TB] FAIL short_over: state=%0d over=%b want 4 1", state, game_over); end
    vectors++; if (winner !== 2'b10) begin miscompares++; $display("[TB] FAIL short_winner: got %b want 10", winner); end
    rule = 3'b100;
    pulse_start();
    vectors++; if (state !== 3'd1 || game_over !== 1'b0) begin miscompares++; $display("[TB] FAIL restart: state=%0d over=%b want 1 0", state, game_over); end
    vectors++; if (p1_point !== 4'd0 || p2_point !== 4'd0 || winner !== 2'b00) begin miscompares++; $display("[TB] FAIL restart_clear: %0d/%0d w=%b want 0/0 00", p1_point, p2_point, winner); end
  endtask

  task automatic test_long_match();
    bit ok;
    logic [10:0] xs [5];
    logic [2:0]  exp_st [5];
    xs     = '{11'd994, 11'd994, 11'd0, 11'd994, 11'd994};
    exp_st = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd4};
    for (int i = 0; i < 5; i++) begin
      wait_state(3'd2, 40, ok);
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL long_rally[%0d]: timeout, state=%0d", i, state); end
      drive_ball(xs[i]);
      if (i == 0) rule = 3'b000;
      wait_leave(3'd3, 40, ok);
      vectors++; if (state !== exp_st[i]) begin miscompares++; $display("[TB] FAIL long_after[%0d]: state=%0d want %0d", i, state, exp_st[i]); end
    end
    vectors++; if (p1_point !== 4'd4 || p2_point !== 4'd1 || winner !== 2'b01) begin miscompares++; $display("[TB] FAIL long_result: %0d/%0d w=%b want 4/1 01", p1_point, p2_point, winner); end
  endtask

  task automatic test_reset_midpoint();
    bit ok;
    pulse_start();
    wait_state(3'd2, 40, ok);
    drive_ball(11'd994);
    vectors++; if (state !== 3'd3 || serve_dir !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset: state=%0d dir=%b want 3 1", state, serve_dir); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (state !== 3'd0 || p1_point !== 4'd0 || p2_point !== 4'd0) begin miscompares++; $display("[TB] FAIL async_reset: state=%0d %0d/%0d want 0 0/0", state, p1_point, p2_point); end
    vectors++; if (serve_dir !== 1'b0 || winner !== 2'b00 || game_over !== 1'b0 || b_rst !== 1'b0 || b_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_flags: dir=%b w=%b over=%b b_rst=%b b_clk=%b want 0", serve_dir, winner, game_over, b_rst, b_clk); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL post_reset_idle: got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_start_serve();
    test_point_p1();
    test_speedup();
    test_tick_collision();
    test_game_over();
    test_long_match();
    test_reset_midpoint();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
